// File: rtl/lights_sequencer_if.sv
// Start key, LFSR, delay timer and LED/go signals of the starting-lights sequencer.
// slave is the sequencer side; master is the environment (key, LFSR, timer, display).
interface lights_sequencer_if #(
    parameter int NUM_LEDS = 10
);
    logic                start;
    logic [15:0]         rand_val;
    logic                delay_time_out;
    logic [15:0]         delay_n;
    logic                delay_trigger;
    logic [NUM_LEDS-1:0] ledr;
    logic                en_lfsr;
    logic                busy;
    logic                go;

    modport master (
        output start, rand_val, delay_time_out,
        input  delay_n, delay_trigger, ledr, en_lfsr, busy, go
    );

    modport slave (
        input  start, rand_val, delay_time_out,
        output delay_n, delay_trigger, ledr, en_lfsr, busy, go
    );
endinterface

// File: rtl/lights_sequencer.sv
// Starting-lights sequencer: lights LEDs one per STEP_N timer period, holds for a floored
// random period, then blanks and pulses go. All outputs registered; start ignored while busy.
module lights_sequencer #(
    parameter int          NUM_LEDS = 10,
    parameter logic [15:0] STEP_N   = 16'd499,
    parameter logic [15:0] MIN_RAND = 16'd250
) (
    input  logic               clk,
    input  logic               rst,
    lights_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, STEP, GAP, RAND} state_t;

    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] LED_FULL = '1;

    state_t              state_q, state_d;
    logic [NUM_LEDS-1:0] ledr_q, ledr_d;
    logic [15:0]         n_q, n_d;
    logic [15:0]         rand_q, rand_d;
    logic                trig_q, trig_d;
    logic                go_q, go_d;
    logic                busy_q, busy_d;
    logic                en_q, en_d;
    logic [NUM_LEDS-1:0] led_shift;
    logic [15:0]         rand_floor;

    assign led_shift  = (ledr_q << 1) | LED_ONE;
    assign rand_floor = (bus.rand_val < MIN_RAND) ? MIN_RAND : bus.rand_val;

    always_comb begin
        state_d = state_q;
        ledr_d  = ledr_q;
        n_d     = n_q;
        rand_d  = rand_q;
        trig_d  = trig_q;
        go_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STEP;
                    ledr_d  = '0;
                    n_d     = STEP_N;
                    trig_d  = 1'b1;
                end
            end
            STEP: begin
                if (bus.delay_time_out) begin
                    ledr_d  = led_shift;
                    trig_d  = 1'b0;
                    state_d = GAP;
                    if (led_shift == LED_FULL) begin
                        rand_d = rand_floor;
                    end
                end
            end
            // Trigger is held low for one whole cycle so the timer always clears.
            GAP: begin
                trig_d = 1'b1;
                if (ledr_q == LED_FULL) begin
                    n_d     = rand_q;
                    state_d = RAND;
                end else begin
                    n_d     = STEP_N;
                    state_d = STEP;
                end
            end
            RAND: begin
                if (bus.delay_time_out) begin
                    ledr_d  = '0;
                    go_d    = 1'b1;
                    trig_d  = 1'b0;
                    n_d     = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        en_d   = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ledr_q  <= '0;
            n_q     <= '0;
            rand_q  <= '0;
            trig_q  <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ledr_q  <= ledr_d;
            n_q     <= n_d;
            rand_q  <= rand_d;
            trig_q  <= trig_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
        end
    end

    assign bus.ledr          = ledr_q;
    assign bus.delay_n       = n_q;
    assign bus.delay_trigger = trig_q;
    assign bus.go            = go_q;
    assign bus.busy          = busy_q;
    assign bus.en_lfsr       = en_q;
endmodule

// File: tb/tb_lights_sequencer.sv
// Bench for lights_sequencer: behavioural delay timer plus a reference model that predicts
// every output from the sequence start edge and the LED/go timing formulas.
module tb_lights_sequencer;
    localparam int          NUM_LEDS = 3;
    localparam logic [15:0] STEP_N   = 16'd4;
    localparam logic [15:0] MIN_RAND = 16'd2;
    localparam int          PERIOD   = int'(STEP_N) + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lights_sequencer_if #(.NUM_LEDS(NUM_LEDS)) bus();

    lights_sequencer #(
        .NUM_LEDS (NUM_LEDS),
        .STEP_N   (STEP_N),
        .MIN_RAND (MIN_RAND)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Delay timer: time_out rises N+1 edges after trigger is first seen high.
    int   tmr_cnt;
    logic noise;
    bit   noise_en;
    always @(posedge clk or posedge rst) begin
        if (rst) tmr_cnt <= 0;
        else     tmr_cnt <= bus.delay_trigger ? tmr_cnt + 1 : 0;
    end
    assign bus.delay_time_out = (tmr_cnt >= int'(bus.delay_n) + 1) || noise;

    int checks = 0;
    int errors = 0;
    int t = 0;

    bit active, r_known;
    int k, g, rr;

    logic [31:0] e_ledr, e_n;
    logic        e_go, e_busy, e_en, e_trig;

    int                  led_seen [0:NUM_LEDS];
    int                  go_seen;
    int                  trig_low_cnt;
    logic [NUM_LEDS-1:0] last_ledr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h exp %0h", tag, t, got, exp);
        end
    endtask

    function automatic int last_edge();
        return k + NUM_LEDS * PERIOD - 1;
    endfunction

    task automatic model_edge();
        if (active && r_known && t > g) active = 1'b0;
        if (!active && bus.start) begin
            active  = 1'b1;
            k       = t;
            r_known = 1'b0;
        end else if (active && !r_known && t == last_edge()) begin
            rr      = (bus.rand_val < MIN_RAND) ? int'(MIN_RAND) : int'(bus.rand_val);
            g       = t + rr + 3;
            r_known = 1'b1;
        end
    endtask

    task automatic model_expect();
        int lc;
        bit lit_edge;
        e_ledr = '0; e_n = '0; e_go = 1'b0; e_busy = 1'b0; e_en = 1'b1; e_trig = 1'b0;
        if (active && r_known && t == g) begin
            e_go = 1'b1;
        end else if (active) begin
            lc = (t - k + 1) / PERIOD;
            if (lc > NUM_LEDS) lc = NUM_LEDS;
            lit_edge = ((t - k + 1) % PERIOD == 0) && (t - k + 1 >= PERIOD) && (t <= last_edge());
            e_busy = 1'b1;
            e_en   = 1'b0;
            e_ledr = (32'd1 << lc) - 32'd1;
            e_trig = !lit_edge;
            e_n    = (r_known && t > last_edge()) ? 32'(rr) : 32'(STEP_N);
        end
    endtask

    task automatic check_outputs();
        model_expect();
        chk("ledr", 32'(bus.ledr), e_ledr);
        chk("delay_n", 32'(bus.delay_n), e_n);
        chk("trigger", 32'(bus.delay_trigger), 32'(e_trig));
        chk("go", 32'(bus.go), 32'(e_go));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("en_lfsr", 32'(bus.en_lfsr), 32'(e_en));
    endtask

    task automatic cycle();
        @(posedge clk);
        t++;
        model_edge();
        @(negedge clk);
        check_outputs();
        if (bus.go) go_seen = t;
        if (bus.busy && !bus.delay_trigger) trig_low_cnt++;
        if (bus.ledr != '0 && bus.ledr != last_ledr) led_seen[$countones(bus.ledr)] = t;
        last_ledr = bus.ledr;
        noise = noise_en && (!e_busy || !e_trig) && ($urandom_range(0, 2) == 0);
    endtask

    task automatic clear_marks();
        for (int i = 0; i <= NUM_LEDS; i++) led_seen[i] = -1;
        go_seen      = -1;
        trig_low_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ledr"}, 32'(bus.ledr), 32'd0);
        chk({tag, "_trigger"}, 32'(bus.delay_trigger), 32'd0);
        chk({tag, "_delay_n"}, 32'(bus.delay_n), 32'd0);
        chk({tag, "_go"}, 32'(bus.go), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_en_lfsr"}, 32'(bus.en_lfsr), 32'd1);
    endtask

    initial begin
        int k0;
        bus.start = 1'b0;
        bus.rand_val = 16'd0;
        noise = 1'b0;
        noise_en = 1'b0;
        active = 1'b0;
        r_known = 1'b0;
        last_ledr = '0;
        clear_marks();

        #12;
        check_reset_values("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // Hold of 10 with stray start pulses at k+8 and k+30.
        clear_marks();
        bus.rand_val = 16'd10;
        k0 = t + 1;
        for (int i = 1; i <= 40; i++) begin
            bus.start = (i == 1 || i == 9 || i == 31);
            cycle();
        end
        chk("led1_edge", 32'(led_seen[1] - k0), 32'd6);
        chk("led2_edge", 32'(led_seen[2] - k0), 32'd13);
        chk("led3_edge", 32'(led_seen[3] - k0), 32'd20);
        chk("go_edge_r10", 32'(go_seen - k0), 32'd33);
        chk("trig_low_cycles", 32'(trig_low_cnt), 32'd3);

        // Random value below the floor.
        clear_marks();
        bus.rand_val = 16'd1;
        k0 = t + 1;
        for (int i = 1; i <= 30; i++) begin
            bus.start = (i == 1);
            cycle();
        end
        chk("go_edge_floor", 32'(go_seen - k0), 32'd25);

        // start held high: back-to-back sequences.
        clear_marks();
        bus.start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            bus.rand_val = 16'($urandom_range(0, 12));
            cycle();
        end
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) cycle();

        // Asynchronous reset in the middle of STEP.
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        chk("pre_rst_ledr", 32'(bus.ledr), 32'd1);
        noise = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_values("rst_async");
        active = 1'b0;
        r_known = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Randomized traffic with spurious time_out in IDLE/GAP.
        noise_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.start    = ($urandom_range(0, 5) == 0);
            bus.rand_val = 16'($urandom_range(0, 15));
            cycle();
        end
        noise_en = 1'b0;
        noise = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
